ifetch_queue: RTL

- Parametrised instruction-fetch front end that replaces the single-word fetch path between the synchronous instruction ROM and the processor.
- Owns the program counter and streams sequential reads from a 1-cycle-latency synchronous memory.
- Buffers returned words, each with its fetch address, in a show-ahead queue.
- Supports redirect (branch/jump) with flush of queued and in-flight words.

---
 rtl/ifetch_queue_pkg.sv | 34 +++
 rtl/ifetch_queue_if.sv | 34 +++
 rtl/ifetch_queue_fifo.sv | 66 ++++++
 rtl/ifetch_queue.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// ifq_pkg: shared types and defaults for the instruction-fetch queue.
// Holds the controller state encoding, the default widths and the queue
// entry layout, plus a saturating adder used by the optional event counters.
package ifq_pkg;

    localparam int DATA_W_DEF = 32'd16;
    localparam int ADDR_W_DEF = 32'd16;
    localparam int DEPTH_DEF  = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        REDIR = 2'd3
    } ifq_state_t;

    // Queue entry at the default widths: returned word plus its fetch address
    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [ADDR_W_DEF-1:0] pc;
    } ifq_entry_t;

    // 32-bit add that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] inc);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, inc};
        if (sum[32]) begin
            return 32'hFFFF_FFFF;
        end else begin
            return sum[31:0];
        end
    endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: memory-side and consumer-side signals of the fetch queue.
// master = the fetch unit, slave = memory + consumer environment.
interface ifetch_queue_if
    import ifq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
);
    localparam int CW = $clog2(DEPTH + 1);

    logic              Run;
    logic [ADDR_W-1:0] MemAddr;
    logic              MemRd;
    logic [DATA_W-1:0] MemData;
    logic [DATA_W-1:0] Instr;
    logic [ADDR_W-1:0] InstrPC;
    logic              InstrValid;
    logic              InstrTake;
    logic              Redirect;
    logic [ADDR_W-1:0] RedirectPC;
    logic [CW-1:0]     Count;

    modport master (
        input  Run, MemData, InstrTake, Redirect, RedirectPC,
        output MemAddr, MemRd, Instr, InstrPC, InstrValid, Count
    );

    modport slave (
        output Run, MemData, InstrTake, Redirect, RedirectPC,
        input  MemAddr, MemRd, Instr, InstrPC, InstrValid, Count
    );

endinterface

// File: rtl/ifetch_queue_fifo.sv
// ifq_fifo: show-ahead circular buffer. The head entry is visible without a
// pop; flush empties the buffer and wins over a simultaneous push or pop.
module ifq_fifo #(
    parameter int WIDTH = 32'd32,
    parameter int DEPTH = 32'd4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests: pops on empty and pushes into a full buffer are dropped
    always_comb begin
        do_pop_s  = pop && !flush && (count_r != {CW{1'b0}});
        do_push_s = push && !flush && ((count_r != CNT_FULL) || do_pop_s);
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; no reset needed because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch front end. Owns the PC, streams reads from
// a 1-cycle-latency synchronous memory and buffers {word, address} pairs in
// a show-ahead queue. Redirect flushes queued and in-flight words.
// Optional build macro IFQ_PERF_COUNTERS_EN adds FetchCount, FlushCount and
// DropCount saturating event counters.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DEPTH    = DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic           Clock,
    input  logic           Reset,
    ifetch_queue_if.master bus
`ifdef IFQ_PERF_COUNTERS_EN
    ,
    output logic [31:0]    FetchCount,
    output logic [31:0]    FlushCount,
    output logic [31:0]    DropCount
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;
    localparam logic [OW-1:0]     DEPTH_O = OW'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1'b1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    ifq_state_t        state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pend_pc_r;
    logic              pending_r;
    logic [CW-1:0]     count_s;
    logic              take_s;
    logic              pop_s;
    logic              issue_s;
    logic [OW-1:0]     occ_s;
    logic [OW-1:0]     occ_next_s;
    entry_t            wr_entry_s;
    entry_t            head_s;

    // Credit and issue: occ_s is what the queue will hold once this cycle's
    // pop and any pending return settle; a new read needs a free slot there.
    always_comb begin
        take_s     = bus.InstrTake && (count_s != {CW{1'b0}});
        pop_s      = take_s && !bus.Redirect;
        occ_s      = OW'(count_s) + OW'(pending_r) - OW'(take_s);
        issue_s    = (state_r == FETCH) && bus.Run && !bus.Redirect && !Reset
                     && (occ_s < DEPTH_O);
        occ_next_s = occ_s + OW'(issue_s);
        wr_entry_s = '{data: bus.MemData, pc: pend_pc_r};
    end

    // Controller: Redirect wins everywhere, REDIR always lasts one cycle
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= IDLE;
        end else if (bus.Redirect) begin
            state_r <= REDIR;
        end else begin
            case (state_r)
                IDLE:    state_r <= bus.Run ? FETCH : IDLE;
                FETCH: begin
                    if (!bus.Run) begin
                        state_r <= IDLE;
                    end else if (occ_next_s >= DEPTH_O) begin
                        state_r <= FULL;
                    end else begin
                        state_r <= FETCH;
                    end
                end
                FULL: begin
                    if (!bus.Run) begin
                        state_r <= IDLE;
                    end else if (occ_s < DEPTH_O) begin
                        state_r <= FETCH;
                    end else begin
                        state_r <= FULL;
                    end
                end
                REDIR:   state_r <= bus.Run ? FETCH : IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // PC and the in-flight read tracker (address remembered for the return)
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_r      <= RESET_PC;
            pend_pc_r <= RESET_PC;
            pending_r <= 1'b0;
        end else begin
            pending_r <= issue_s;
            if (issue_s) begin
                pend_pc_r <= pc_r;
            end
            if (bus.Redirect) begin
                pc_r <= bus.RedirectPC;
            end else if (issue_s) begin
                pc_r <= pc_r + PC_ONE;
            end
        end
    end

    // A return arriving in a Redirect cycle is dropped by the flush
    ifq_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (Clock),
        .rst   (Reset),
        .push  (pending_r),
        .pop   (pop_s),
        .flush (bus.Redirect),
        .din   (wr_entry_s),
        .head  (head_s),
        .count (count_s)
    );

    assign bus.MemRd      = issue_s;
    assign bus.MemAddr    = pc_r;
    assign bus.Instr      = head_s.data;
    assign bus.InstrPC    = head_s.pc;
    assign bus.InstrValid = (count_s != {CW{1'b0}});
    assign bus.Count      = count_s;

`ifdef IFQ_PERF_COUNTERS_EN
    logic [31:0] fetch_cnt_r;
    logic [31:0] flush_cnt_r;
    logic [31:0] drop_cnt_r;
    logic [31:0] drop_inc_s;

    // Words thrown away by a redirect: everything queued plus the in-flight one
    always_comb begin
        if (bus.Redirect) begin
            drop_inc_s = 32'(count_s) + 32'(pending_r);
        end else begin
            drop_inc_s = 32'h0000_0000;
        end
    end

    // Saturating event counters
    always_ff @(posedge Clock) begin
        if (Reset) begin
            fetch_cnt_r <= 32'h0000_0000;
            flush_cnt_r <= 32'h0000_0000;
            drop_cnt_r  <= 32'h0000_0000;
        end else begin
            fetch_cnt_r <= sat_add32(fetch_cnt_r, {31'd0, issue_s});
            flush_cnt_r <= sat_add32(flush_cnt_r, {31'd0, bus.Redirect});
            drop_cnt_r  <= sat_add32(drop_cnt_r, drop_inc_s);
        end
    end

    assign FetchCount = fetch_cnt_r;
    assign FlushCount = flush_cnt_r;
    assign DropCount  = drop_cnt_r;
`endif

endmodule
